// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the program counter, presents it to a combinational instruction
// memory, and captures the returned word into an IF/ID register that is
// handed to decode with a valid/ready handshake. Execute can redirect the
// PC. A misaligned redirect or a fetch past the end of memory parks the
// stage in a sticky FAULT state until reset.
//
// Handshake: out_valid/out_instr/out_pc/out_pc_plus4 form one beat. A beat
// transfers on a rising edge where out_valid && out_ready. While
// out_valid && !out_ready the beat is held unchanged. out_valid never
// depends combinationally on out_ready.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [1:0]  fsm_state
);

    // FSM encoding; FSM state is also visible on fsm_state.
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Fault cause encoding.
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;

    // Range limit widened by one bit so pc+3 cannot wrap past the compare.
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

    // Registered state.
    logic [1:0]  state;
    logic [31:0] pc;

    // Next-state values.
    logic [1:0]  state_n;
    logic [31:0] pc_n;
    logic        valid_n;
    logic [31:0] instr_n;
    logic [31:0] opc_n;
    logic [31:0] opc4_n;
    logic [1:0]  cause_n;

    // Helpers for the RUN decisions.
    logic        accept;
    logic [31:0] pc_plus4;
    logic [32:0] fetch_last;
    logic        fetch_oob;
    logic        redirect_misaligned;

    assign imem_addr = pc;
    assign fault     = (state == ST_FAULT);
    assign fsm_state = state;

    // Derived fetch conditions: capture slot, sequential PC, range and
    // alignment checks.
    always_comb begin
        accept              = !out_valid || out_ready;
        pc_plus4            = pc + 32'd4;
        fetch_last          = {1'b0, pc} + 33'd3;
        fetch_oob           = (fetch_last >= IMEM_LIMIT);
        redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    end

    // Next-state logic: redirect beats accept, accept beats stall; faults are
    // evaluated redirect-first and always discard the held instruction.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = out_valid;
        instr_n = out_instr;
        opc_n   = out_pc;
        opc4_n  = out_pc_plus4;
        cause_n = fault_cause;

        case (state)
            ST_BOOT: begin
                // One idle cycle after reset release; redirects ignored.
                valid_n = 1'b0;
                state_n = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    if (redirect_misaligned) begin
                        state_n = ST_FAULT;
                        cause_n = CAUSE_MISALIGN;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (accept) begin
                    if (fetch_oob) begin
                        state_n = ST_FAULT;
                        cause_n = CAUSE_RANGE;
                        valid_n = 1'b0;
                    end else begin
                        instr_n = imem_instr;
                        opc_n   = pc;
                        opc4_n  = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end
                end
                // Otherwise stalled: everything holds.
            end

            ST_FAULT: begin
                // Frozen until reset.
                valid_n = 1'b0;
            end

            default: begin
                // Unused encoding: park safely in FAULT.
                state_n = ST_FAULT;
                valid_n = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            out_valid    <= 1'b0;
            out_instr    <= 32'd0;
            out_pc       <= 32'd0;
            out_pc_plus4 <= 32'd0;
            fault_cause  <= CAUSE_NONE;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            out_valid    <= valid_n;
            out_instr    <= instr_n;
            out_pc       <= opc_n;
            out_pc_plus4 <= opc4_n;
            fault_cause  <= cause_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a scoreboard of expected
// {pc, instr} beats popped on every out_valid && out_ready handshake.
module tb_if_stage;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];

    if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(8192)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4),
        .fault(fault),
        .fault_cause(fault_cause),
        .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0020_0093;
            32'h4:   mem_word = 32'h0030_0113;
            32'h8:   mem_word = 32'h0011_01B3;
            default: mem_word = 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", out_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                logic [31:0] epc;
                e   = exp_q.pop_front();
                epc = e[63:32];
                check_eq("sb_pc", out_pc, epc);
                check_eq("sb_instr", out_instr, e[31:0]);
                check_eq("sb_pc4", out_pc_plus4, epc + 32'd4);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values.
        #12;
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_cause", 32'(fault_cause), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_pc4", out_pc_plus4, 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_BOOT));

        // Release and stream 0, 4; then stall on 4.
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        step(1);
        check_eq("boot_valid", 32'(out_valid), 32'd0);
        check_eq("boot_to_run", 32'(fsm_state), 32'(ST_RUN));
        step(1);
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("first_pc", out_pc, 32'h0);
        step(1);
        check_eq("second_pc", out_pc, 32'h4);
        out_ready = 1'b0;
        step(3);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_pc", out_pc, 32'h4);
        check_eq("stall_instr", out_instr, 32'h0030_0113);
        check_eq("stall_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        step(1);
        check_eq("resume_pc", out_pc, 32'h8);
        check_eq("resume_instr", out_instr, 32'h0011_01B3);
        check_eq("resume_pc4", out_pc_plus4, 32'hC);

        // Redirect while stalled on 8: the held beat is flushed.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        check_eq("redir_flush", 32'(out_valid), 32'd0);
        check_eq("redir_addr", imem_addr, 32'h40);
        for (int i = 0; i < 12; i++) push_exp(32'h40 + 32'(4 * i));
        step(1);
        check_eq("redir_valid", 32'(out_valid), 32'd1);
        check_eq("redir_pc", out_pc, 32'h40);

        // Random backpressure until the scoreboard drains.
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        out_ready = 1'b0;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        // Aligned redirect to 0x100, then a misaligned one.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        check_eq("r100_flush", 32'(out_valid), 32'd0);
        check_eq("r100_addr", imem_addr, 32'h100);
        step(1);
        check_eq("r100_valid", 32'(out_valid), 32'd1);
        check_eq("r100_pc", out_pc, 32'h100);
        check_eq("r100_instr", out_instr, mem_word(32'h100));
        check_eq("r100_next", imem_addr, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step(1);
        check_eq("mis_fault", 32'(fault), 32'd1);
        check_eq("mis_cause", 32'(fault_cause), 32'd1);
        check_eq("mis_valid", 32'(out_valid), 32'd0);
        check_eq("mis_pc_frozen", imem_addr, 32'h104);
        check_eq("mis_state", 32'(fsm_state), 32'(ST_FAULT));
        redirect_pc = 32'h200;
        out_ready   = 1'b1;
        step(3);
        check_eq("flt_sticky", 32'(fault), 32'd1);
        check_eq("flt_cause", 32'(fault_cause), 32'd1);
        check_eq("flt_valid", 32'(out_valid), 32'd0);
        check_eq("flt_pc", imem_addr, 32'h104);
        redirect_valid = 1'b0;

        // Reset pulse mid-cycle clears the fault without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_fault", 32'(fault), 32'd0);
        check_eq("arst_cause", 32'(fault_cause), 32'd0);
        check_eq("arst_addr", imem_addr, 32'h0);
        check_eq("arst_state", 32'(fsm_state), 32'(ST_BOOT));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        step(1);
        check_eq("reboot_boot", 32'(out_valid), 32'd0);
        step(1);
        check_eq("reboot_valid", 32'(out_valid), 32'd1);
        check_eq("reboot_pc", out_pc, 32'h0);
        check_eq("reboot_instr", out_instr, 32'h0020_0093);
        check_eq("reboot_addr", imem_addr, 32'h4);

        // Last word in memory is delivered, the next fetch faults.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1FFC;
        step(1);
        redirect_valid = 1'b0;
        check_eq("oor_addr", imem_addr, 32'h1FFC);
        check_eq("oor_flush", 32'(out_valid), 32'd0);
        push_exp(32'h1FFC);
        out_ready = 1'b1;
        step(1);
        check_eq("oor_last_valid", 32'(out_valid), 32'd1);
        check_eq("oor_last_pc", out_pc, 32'h1FFC);
        check_eq("oor_last_pc4", out_pc_plus4, 32'h2000);
        check_eq("oor_next_addr", imem_addr, 32'h2000);
        step(1);
        check_eq("oor_fault", 32'(fault), 32'd1);
        check_eq("oor_cause", 32'(fault_cause), 32'd2);
        check_eq("oor_valid", 32'(out_valid), 32'd0);
        check_eq("oor_pc", imem_addr, 32'h2000);
        out_ready = 1'b0;

        // Asynchronous reset asserted while a beat is held by a stall.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("oor_rst_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4);
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_pc", out_pc, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midstall_valid", 32'(out_valid), 32'd0);
        check_eq("midstall_fault", 32'(fault), 32'd0);
        check_eq("midstall_addr", imem_addr, 32'h0);
        check_eq("midstall_pc", out_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        check_eq("post_boot", 32'(out_valid), 32'd0);
        check_eq("post_boot_state", 32'(fsm_state), 32'(ST_RUN));
        step(1);
        check_eq("post_valid", 32'(out_valid), 32'd1);
        check_eq("post_pc", out_pc, 32'h0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned word into an IF/ID register with a valid/ready handshake toward decode.
- Handles redirects from execute (branch/jump) and halts on misaligned or out-of-range fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_BYTES, 8192, instruction memory size in bytes; fetch address must satisfy addr+3 < IMEM_BYTES.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; equals pc register
imem_instr  input  32  instruction word from memory, combinational from imem_addr
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  32  redirect target
out_ready  input  1  decode accepts out_* this cycle
out_valid  output  1  IF/ID register holds a valid instruction
out_instr  output  32  fetched instruction
out_pc  output  32  address of out_instr
out_pc_plus4  output  32  out_pc + 4
fault  output  1  sticky fetch fault
fault_cause  output  2  0 none, 1 misaligned redirect, 2 out of range

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=BOOT, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fault=0, fault_cause=0. imem_addr=RESET_PC during reset.
- States: BOOT, RUN, FAULT.
- BOOT: lasts exactly one cycle after rst_n deasserts. out_valid stays 0. Transitions to RUN. Redirects are ignored in BOOT.
- RUN, capture condition: accept = !out_valid || out_ready.
  - On accept with no redirect: out_instr<=imem_instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
  - Throughput is one instruction per cycle under continuous out_ready.
  - Latency: the instruction at address A appears on out_* one cycle after pc==A.
- Stall: when out_valid && !out_ready, pc and all out_* hold unchanged. out_instr must not change while stalled.
- Redirect:
  - redirect_valid in RUN has priority over stall and accept.
  - Next cycle: pc<=redirect_pc, out_valid<=0 (the held or wrong-path instruction is flushed), out_* data regs hold.
  - The target instruction appears on out_* two cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins; each flushes.
- Faults, checked in RUN, redirect first:
  - redirect_valid with redirect_pc[1:0]!=0: state<=FAULT, fault_cause<=1, out_valid<=0, pc unchanged.
  - Otherwise, if an accept would fetch with pc+3 >= IMEM_BYTES: state<=FAULT, fault_cause<=2, out_valid<=0, no capture.
  - A valid instruction already held at fault entry is discarded.
- FAULT: fault=1 (asserted as soon as the state is FAULT). Stays there until reset. Ignores redirect_valid and out_ready. out_valid=0. pc frozen.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32; the out-of-range check catches wrap before it is used.
- Reset mid-operation: all state clears immediately and asynchronously. The first fetch after release is RESET_PC, following the BOOT cycle.

Test Plan:
- Reset then run, out_ready=1, IM holding 00200093,00300113,001101B3 at 0/4/8: out_valid rises 2 cycles after rst_n release; out_pc sequence 0,4,8 with matching out_instr and out_pc_plus4 4,8,12.
- Stall: drop out_ready for 3 cycles while out_pc=4: out_pc=4, out_instr=00300113 held, imem_addr=8 held; resume gives out_pc=8 next accepted cycle, no skip or duplicate.
- Redirect while stalled (out_pc=8, out_ready=0, redirect_pc=0x40): next cycle out_valid=0, imem_addr=0x40; the following cycle out_pc=0x40.
- Misaligned redirect_pc=0x42: fault=1, fault_cause=1, out_valid=0 permanently; a later valid redirect has no effect; rst_n pulse clears fault and restarts at RESET_PC.
- Out of range: redirect_pc=IMEM_BYTES-4 (0x1FFC): instruction at 0x1FFC delivered; the next fetch faults with fault_cause=2 and out_valid=0.
- Async reset asserted mid-stall: out_valid and fault drop immediately without a clock edge; BOOT cycle observed after release.
